rgb_pwm_fader: RTL



---
 rtl/rgb_pwm_fader.sv | 104 ++++++++++
 1 files changed

// File: rtl/rgb_pwm_fader.sv
// Fades three active-low PWM LEDs toward a registered RGB colour target, one duty step per prescaler tick.
// Inputs take 1 cycle to register; the LED outputs are registered and duty changes are applied at PWM wrap.
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          color_i,
  input  logic [PWM_BITS-1:0] level_i,
  output logic                rLed,
  output logic                gLed,
  output logic                bLed,
  output logic                busy_o
);

  localparam int PS_W = $clog2(STEP_DIV);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  typedef enum logic {IDLE, FADE} state_t;

  state_t                        state, state_nxt;
  logic [2:0]                    color_r;
  logic [PWM_BITS-1:0]           level_r;
  logic [2:0][PWM_BITS-1:0]      target, duty, duty_nxt, shadow;
  logic [PWM_BITS-1:0]           pwm_cnt;
  logic [PS_W-1:0]               prescaler;
  logic [2:0]                    led_n;
  logic                          tick;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      target[i] = color_r[i] ? level_r : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (duty != target) state_nxt = FADE;
      FADE:    if (duty == target) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tick = (state == FADE) && (prescaler == PS_LAST);

  // Direction is taken from the current target, so a retarget landing on a tick steps the new way.
  always_comb begin
    duty_nxt = duty;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (duty[i] < target[i]) begin
          duty_nxt[i] = duty[i] + 1'b1;
        end else if (duty[i] > target[i]) begin
          duty_nxt[i] = duty[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      color_r   <= '0;
      level_r   <= '0;
      duty      <= '0;
      shadow    <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
      led_n     <= 3'b111;
    end else begin
      state   <= state_nxt;
      color_r <= color_i;
      level_r <= level_i;
      duty    <= duty_nxt;

      if (state != FADE || state_nxt != FADE || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      // Shadow only reloads at the period boundary so a pulse is never cut short or stretched.
      if (pwm_cnt == CNT_LAST) begin
        pwm_cnt <= '0;
        shadow  <= duty;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end

      for (int i = 0; i < 3; i++) begin
        led_n[i] <= ~(pwm_cnt < shadow[i]);
      end
    end
  end

  assign rLed   = led_n[2];
  assign gLed   = led_n[1];
  assign bLed   = led_n[0];
  assign busy_o = (state == FADE);

endmodule
